// File: rtl/matrix_a_loader.sv
// rtl/matrix_a_loader.sv - streams one DEPTHxDEPTH matrix into a buffer, then drains it column by column.
// Build option: LOADER_TRANSPOSE_EN (column-major input; row/col outputs swapped).
module matrix_a_loader #(
    parameter int BITS  = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load_start,
    input  logic            s_valid,
    input  logic [BITS-1:0] s_data,
    output logic            s_ready,
    output logic            WrEn,
    output logic [BITS-1:0] d,
    output logic [AW-1:0]   row,
    output logic [AW-1:0]   col,
    output logic            load_done,
    input  logic            stream_start,
    output logic            en,
    output logic            stream_done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL,
        STREAM
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] fast_cnt;
    logic [AW-1:0] slow_cnt;
    logic          accept;
    logic          fast_wrap;
    logic          last_beat;
    logic          last_drain;

    assign s_ready    = (state == LOAD);
    assign load_done  = (state == FULL);
    assign en         = (state == STREAM);
    // A beat presented together with clr is dropped.
    assign accept     = s_valid && s_ready && !clr;
    assign fast_wrap  = (fast_cnt == AW'(DEPTH - 1));
    assign last_beat  = accept && fast_wrap && (slow_cnt == AW'(DEPTH - 1));
    assign last_drain = (state == STREAM) && fast_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (load_start)   state_nxt = LOAD;
                LOAD:    if (last_beat)    state_nxt = FULL;
                FULL:    if (stream_start) state_nxt = STREAM;
                STREAM:  if (last_drain)   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fast_cnt    <= '0;
            slow_cnt    <= '0;
            WrEn        <= 1'b0;
            d           <= '0;
            row         <= '0;
            col         <= '0;
            stream_done <= 1'b0;
        end else begin
            WrEn        <= accept;
            stream_done <= last_drain && !clr;
            if (accept) begin
                d <= s_data;
`ifdef LOADER_TRANSPOSE_EN
                row <= fast_cnt;
                col <= slow_cnt;
`else
                row <= slow_cnt;
                col <= fast_cnt;
`endif
            end
            // The fast counter doubles as the drain-cycle counter in STREAM.
            if (clr || last_beat || last_drain) begin
                fast_cnt <= '0;
                slow_cnt <= '0;
            end else if (accept) begin
                if (fast_wrap) begin
                    fast_cnt <= '0;
                    slow_cnt <= slow_cnt + 1'b1;
                end else begin
                    fast_cnt <= fast_cnt + 1'b1;
                end
            end else if (state == STREAM) begin
                fast_cnt <= fast_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_a_loader.sv
// tb/tb_matrix_a_loader.sv - scoreboard bench for matrix_a_loader with a queue-based write model.
module tb_matrix_a_loader;

    localparam int BITS  = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int N     = DEPTH * DEPTH;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr = 1'b0;
    logic            load_start = 1'b0;
    logic            s_valid = 1'b0;
    logic [BITS-1:0] s_data = '0;
    logic            s_ready;
    logic            WrEn;
    logic [BITS-1:0] d;
    logic [AW-1:0]   row;
    logic [AW-1:0]   col;
    logic            load_done;
    logic            stream_start = 1'b0;
    logic            en;
    logic            stream_done;

    typedef struct packed {
        logic [BITS-1:0] data;
        logic [AW-1:0]   r;
        logic [AW-1:0]   c;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    matrix_a_loader #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .load_start   (load_start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .WrEn         (WrEn),
        .d            (d),
        .row          (row),
        .col          (col),
        .load_done    (load_done),
        .stream_start (stream_start),
        .en           (en),
        .stream_done  (stream_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Element k of the input stream lands at (k/DEPTH, k%DEPTH), swapped in the transpose build.
    function automatic wr_t model_write(input int k, input logic [BITS-1:0] v);
        wr_t w;
        w.data = v;
`ifdef LOADER_TRANSPOSE_EN
        w.r = AW'(k % DEPTH);
        w.c = AW'(k / DEPTH);
`else
        w.r = AW'(k / DEPTH);
        w.c = AW'(k % DEPTH);
`endif
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst_n && WrEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got row=%0d col=%0d d=%0d, expected no write", row, col, d);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_data", 32'(d), 32'(e.data));
                check("wr_row", 32'(row), 32'(e.r));
                check("wr_col", 32'(col), 32'(e.c));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 0);
        check({tag, "_WrEn"}, 32'(WrEn), 0);
        check({tag, "_d"}, 32'(d), 0);
        check({tag, "_row"}, 32'(row), 0);
        check({tag, "_col"}, 32'(col), 0);
        check({tag, "_load_done"}, 32'(load_done), 0);
        check({tag, "_en"}, 32'(en), 0);
        check({tag, "_stream_done"}, 32'(stream_done), 0);
    endtask

    // gap_mode: 0 back-to-back, 1 alternate valid/idle, 2 random idle gaps.
    task automatic load(input int nbeats, input int gap_mode);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            logic [BITS-1:0] v;
            int gaps;
            gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            if (k > 0) begin
                for (int g = 0; g < gaps; g++) begin
                    s_valid = 1'b0;
                    s_data  = BITS'($urandom);
                    step();
                end
            end
            v       = (gap_mode == 0 && k < 256) ? BITS'(k) : BITS'($urandom);
            s_valid = 1'b1;
            s_data  = v;
            exp_q.push_back(model_write(k, v));
            @(negedge clk);
            if (k == 0 || k == nbeats - 1)
                check("s_ready_in_load", 32'(s_ready), 1);
            if (k == N - 1)
                check("load_done_before_last", 32'(load_done), 0);
            step();
        end
        s_valid = 1'b0;
        if (nbeats == N) begin
            @(negedge clk);
            check("load_done_after_last", 32'(load_done), 1);
            check("s_ready_after_last", 32'(s_ready), 0);
            step();
            check("queue_drained", 32'(exp_q.size()), 0);
        end
    endtask

    task automatic stream();
        int n_en;
        int n_done;
        n_en   = 0;
        n_done = 0;
        stream_start = 1'b1;
        step();
        stream_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en === 1'b1) n_en++;
            if (stream_done === 1'b1) begin
                n_done++;
                check("en_before_done", 32'(n_en), DEPTH);
                check("en_low_at_done", 32'(en), 0);
            end
        end
        check("en_cycles", 32'(n_en), DEPTH);
        check("stream_done_pulses", 32'(n_done), 1);
        check("idle_load_done", 32'(load_done), 0);
        step();
        n_en = 0;
        stream_start = 1'b1;
        step();
        stream_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (en === 1'b1 || stream_done === 1'b1) n_en++;
        end
        check("second_stream_ignored", 32'(n_en), 0);
        step();
    endtask

    task automatic valid_without_start(input string tag);
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = BITS'($urandom);
            @(negedge clk);
            check({tag, "_s_ready"}, 32'(s_ready), 0);
            check({tag, "_WrEn"}, 32'(WrEn), 0);
            step();
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check_all_zero("post_reset");
        valid_without_start("no_start");

        load(N, 0);
        stream();

        load(N, 1);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        @(negedge clk);
        check("load_start_in_full_ignored", 32'(load_done), 1);
        check("s_ready_in_full", 32'(s_ready), 0);
        step();
        stream();

        load(N, 2);
        stream();

        load(20, 0);
        step();
        clr          = 1'b1;
        s_valid      = 1'b1;
        s_data       = BITS'($urandom);
        load_start   = 1'b1;
        stream_start = 1'b1;
        step();
        clr          = 1'b0;
        s_valid      = 1'b0;
        load_start   = 1'b0;
        stream_start = 1'b0;
        @(negedge clk);
        check("clr_s_ready", 32'(s_ready), 0);
        check("clr_WrEn", 32'(WrEn), 0);
        check("clr_en", 32'(en), 0);
        step();
        valid_without_start("after_clr");
        load(N, 0);
        stream();

        load(20, 2);
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_load_reset");
        step();
        rst_n = 1'b1;
        step();
        valid_without_start("after_reset");
        load(N, 2);
        stream();

        step();
        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
